// File: rtl/spi_byte_streamer.sv
// spi_byte_streamer: TX/RX byte FIFOs feeding an SPI master over its DV/Ready handshake
module spi_byte_streamer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Wr_DV,
    input  logic [7:0]               i_Wr_Byte,
    input  logic                     i_Go,
    input  logic                     i_Rd_En,
    output logic [7:0]               o_Rd_Byte,
    output logic                     o_TX_Full,
    output logic [$clog2(DEPTH):0]   o_TX_Level,
    output logic                     o_RX_Empty,
    output logic [$clog2(DEPTH):0]   o_RX_Level,
    output logic                     o_TX_Ovf,
    output logic                     o_RX_Ovf,
    output logic                     o_Busy,
    output logic [CNT_W-1:0]         o_Xfer_Count,
    output logic                     o_TX_DV,
    output logic [7:0]               o_TX_Byte,
    input  logic                     i_TX_Ready,
    input  logic                     i_RX_DV,
    input  logic [7:0]               i_RX_Byte
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX, WAIT_RDY} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [LW-1:0] r_tx_lvl, r_rx_lvl;
    logic          r_tx_ovf, r_rx_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]    r_tx_byte;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_dv;

    assign w_tx_full  = r_tx_lvl == LW'(DEPTH);
    assign w_tx_empty = r_tx_lvl == '0;
    assign w_rx_full  = r_rx_lvl == LW'(DEPTH);
    assign w_rx_empty = r_rx_lvl == '0;
    assign w_tx_pop   = r_state == ISSUE;
    assign w_tx_push  = i_Wr_DV && (!w_tx_full || w_tx_pop);
    assign w_rx_dv    = (r_state == WAIT_RX) && i_RX_DV;
    assign w_rx_pop   = i_Rd_En && !w_rx_empty;
    assign w_rx_push  = w_rx_dv && (!w_rx_full || w_rx_pop);

    assign o_Rd_Byte    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
    assign o_TX_Full    = w_tx_full;
    assign o_TX_Level   = r_tx_lvl;
    assign o_RX_Empty   = w_rx_empty;
    assign o_RX_Level   = r_rx_lvl;
    assign o_TX_Ovf     = r_tx_ovf;
    assign o_RX_Ovf     = r_rx_ovf;
    assign o_Busy       = r_state != IDLE;
    assign o_Xfer_Count = r_cnt;
    assign o_TX_DV      = r_state == ISSUE;
    assign o_TX_Byte    = r_tx_byte;

    // Next-state logic: one issue per byte, then wait for the echo and for the master to go ready again
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = (i_Go && !w_tx_empty && i_TX_Ready) ? ISSUE : IDLE;
            ISSUE:    w_next = WAIT_RX;
            WAIT_RX:  w_next = i_RX_DV ? WAIT_RDY : WAIT_RX;
            WAIT_RDY: w_next = i_TX_Ready ? IDLE : WAIT_RDY;
            default:  w_next = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since levels gate every read
    always_ff @(posedge i_Clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_Wr_Byte;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= i_RX_Byte;
    end

    // State, pointers, levels, sticky flags, counter and the issued-byte register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_tx_lvl  <= '0;
            r_rx_lvl  <= '0;
            r_tx_ovf  <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_cnt     <= '0;
            r_tx_byte <= 8'h00;
        end else begin
            r_state   <= w_next;
            r_tx_wp   <= r_tx_wp + AW'(w_tx_push);
            r_tx_rp   <= r_tx_rp + AW'(w_tx_pop);
            r_rx_wp   <= r_rx_wp + AW'(w_rx_push);
            r_rx_rp   <= r_rx_rp + AW'(w_rx_pop);
            r_tx_lvl  <= r_tx_lvl + LW'(w_tx_push) - LW'(w_tx_pop);
            r_rx_lvl  <= r_rx_lvl + LW'(w_rx_push) - LW'(w_rx_pop);
            r_tx_ovf  <= r_tx_ovf | (i_Wr_DV && !w_tx_push);
            r_rx_ovf  <= r_rx_ovf | (w_rx_dv && !w_rx_push);
            r_cnt     <= r_cnt + CNT_W'(w_rx_dv);
            r_tx_byte <= (r_state == IDLE && w_next == ISSUE) ? r_tx_mem[r_tx_rp] : r_tx_byte;
        end
    end
endmodule

// File: tb/tb_spi_byte_streamer.sv
// tb_spi_byte_streamer: directed self-checking bench with a simple SPI master model
module tb_spi_byte_streamer;
    logic clk = 1'b0;
    logic rst, wr_dv, go, rd_en, inj_rxdv, loopback;
    logic [7:0] wr_byte, echo;
    logic [7:0] rd_byte, tx_byte, rd_byte_4, tx_byte_4;
    logic tx_full, rx_empty, tx_ovf, rx_ovf, busy, tx_dv;
    logic tx_full_4, rx_empty_4, tx_ovf_4, rx_ovf_4, busy_4, tx_dv_4;
    logic [3:0] tx_level, rx_level, tx_level_4, rx_level_4;
    logic [15:0] xfer;
    logic [3:0] xfer_4;
    logic m_ready, m_rxdv;
    logic [7:0] m_rxb, last_tx;
    int m_cnt, tx_pulses;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    spi_byte_streamer #(.DEPTH(8), .CNT_W(16)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte), .i_Go(go),
        .i_Rd_En(rd_en), .o_Rd_Byte(rd_byte), .o_TX_Full(tx_full), .o_TX_Level(tx_level),
        .o_RX_Empty(rx_empty), .o_RX_Level(rx_level), .o_TX_Ovf(tx_ovf), .o_RX_Ovf(rx_ovf),
        .o_Busy(busy), .o_Xfer_Count(xfer), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .i_TX_Ready(m_ready), .i_RX_DV(m_rxdv | inj_rxdv), .i_RX_Byte(m_rxb)
    );

    spi_byte_streamer #(.DEPTH(8), .CNT_W(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte), .i_Go(go),
        .i_Rd_En(rd_en), .o_Rd_Byte(rd_byte_4), .o_TX_Full(tx_full_4), .o_TX_Level(tx_level_4),
        .o_RX_Empty(rx_empty_4), .o_RX_Level(rx_level_4), .o_TX_Ovf(tx_ovf_4), .o_RX_Ovf(rx_ovf_4),
        .o_Busy(busy_4), .o_Xfer_Count(xfer_4), .o_TX_DV(tx_dv_4), .o_TX_Byte(tx_byte_4),
        .i_TX_Ready(m_ready), .i_RX_DV(m_rxdv | inj_rxdv), .i_RX_Byte(m_rxb)
    );

    // Master model: drops ready on a DV pulse, returns a byte a few cycles later, then goes ready
    always @(posedge clk) begin
        m_rxdv <= 1'b0;
        if (rst) begin
            m_ready   <= 1'b1;
            m_cnt     <= 0;
            m_rxb     <= 8'h00;
            tx_pulses <= 0;
            last_tx   <= 8'h00;
        end else if (tx_dv) begin
            m_ready   <= 1'b0;
            m_cnt     <= 6;
            tx_pulses <= tx_pulses + 1;
            last_tx   <= tx_byte;
            m_rxb     <= loopback ? tx_byte : echo;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_rxdv <= 1'b1;
            if (m_cnt == 1) m_ready <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_dv = 1'b0; rd_en = 1'b0; inj_rxdv = 1'b0; go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_dv = 1'b1; wr_byte = b;
        @(negedge clk);
        wr_dv = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int t = 0;
        while ((32'(xfer) != n || busy) && t < 3000) begin @(negedge clk); t++; end
        chk("xfer_wait", 32'(t < 3000), 1);
    endtask

    task automatic wait_pulses(input int n);
        int t = 0;
        while (tx_pulses < n && t < 3000) begin @(negedge clk); t++; end
        chk("pulse_wait", 32'(t < 3000), 1);
    endtask

    task automatic wait_txdv();
        int t = 0;
        while (!tx_dv && t < 3000) begin @(negedge clk); t++; end
        chk("txdv_wait", 32'(t < 3000), 1);
    endtask

    task automatic wait_rxdv();
        int t = 0;
        while (!m_rxdv && t < 3000) begin @(negedge clk); t++; end
        chk("rxdv_wait", 32'(t < 3000), 1);
    endtask

    initial begin
        loopback = 1'b0; echo = 8'h3C; wr_byte = 8'h00;
        do_reset();
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_rx_level", 32'(rx_level), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_xfer", 32'(xfer), 0);
        chk("rst_ovf", 32'({tx_ovf, rx_ovf}), 0);
        chk("rst_rd_byte", 32'(rd_byte), 0);

        // single byte with fixed echo, including issue latency
        go = 1'b1;
        wr(8'hA5);
        chk("lat_dv_early", 32'(tx_dv), 0);
        chk("lat_level1", 32'(tx_level), 1);
        @(negedge clk);
        chk("lat_dv", 32'(tx_dv), 1);
        chk("lat_byte", 32'(tx_byte), 32'hA5);
        chk("lat_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_dv_once", 32'(tx_dv), 0);
        chk("lat_level0", 32'(tx_level), 0);
        wait_xfers(1);
        repeat (10) @(negedge clk);
        chk("single_pulses", 32'(tx_pulses), 1);
        chk("single_last_tx", 32'(last_tx), 32'hA5);
        chk("single_rd_byte", 32'(rd_byte), 32'h3C);
        chk("single_xfer", 32'(xfer), 1);
        chk("single_busy", 32'(busy), 0);
        chk("single_tx_byte_hold", 32'(tx_byte), 32'hA5);

        // RX_DV while idle is ignored
        inj_rxdv = 1'b1;
        @(negedge clk);
        inj_rxdv = 1'b0;
        chk("ign_xfer", 32'(xfer), 1);
        chk("ign_rx_level", 32'(rx_level), 1);
        rd();
        chk("rd_empty", 32'(rx_empty), 1);
        chk("rd_byte_zero", 32'(rd_byte), 0);
        rd();
        chk("rd_underflow", 32'(rx_level), 0);

        // burst with loopback, TX full and overflow
        do_reset();
        loopback = 1'b1;
        for (int i = 1; i <= 8; i++) wr(8'(i));
        chk("burst_full", 32'(tx_full), 1);
        chk("burst_level", 32'(tx_level), 8);
        chk("burst_no_ovf", 32'(tx_ovf), 0);
        wr(8'h09);
        chk("burst_ovf", 32'(tx_ovf), 1);
        chk("burst_level_ovf", 32'(tx_level), 8);
        go = 1'b1;
        wait_xfers(8);
        chk("burst_pulses", 32'(tx_pulses), 8);
        chk("burst_xfer", 32'(xfer), 8);
        chk("burst_rx_level", 32'(rx_level), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("burst_rd", 32'(rd_byte), i);
            rd();
        end
        chk("burst_rx_empty", 32'(rx_empty), 1);

        // hold via i_Go during the 3rd byte, then write at full during a pop
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'h11 + 8'(i));
        go = 1'b1;
        wait_pulses(3);
        go = 1'b0;
        wait_xfers(3);
        repeat (20) @(negedge clk);
        chk("hold_pulses", 32'(tx_pulses), 3);
        chk("hold_level", 32'(tx_level), 5);
        chk("hold_xfer", 32'(xfer), 3);
        chk("hold_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) wr(8'h19 + 8'(i));
        chk("hold_full", 32'(tx_full), 1);
        go = 1'b1;
        wait_txdv();
        chk("hold_4th_byte", 32'(tx_byte), 32'h14);
        wr_dv = 1'b1; wr_byte = 8'h1C;
        @(negedge clk);
        wr_dv = 1'b0; go = 1'b0;
        chk("popwr_level", 32'(tx_level), 8);
        chk("popwr_no_ovf", 32'(tx_ovf), 0);

        // RX full, simultaneous read+push at full, then RX overflow
        do_reset();
        go = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'h21 + 8'(i));
        wait_xfers(8);
        chk("rxf_level", 32'(rx_level), 8);
        chk("rxf_no_ovf", 32'(rx_ovf), 0);
        chk("rxf_head", 32'(rd_byte), 32'h21);
        wr(8'h29);
        wait_rxdv();
        rd();
        chk("rxsim_level", 32'(rx_level), 8);
        chk("rxsim_no_ovf", 32'(rx_ovf), 0);
        chk("rxsim_head", 32'(rd_byte), 32'h22);
        wr(8'h2A);
        wait_xfers(10);
        chk("rxovf_flag", 32'(rx_ovf), 1);
        chk("rxovf_level", 32'(rx_level), 8);
        chk("rxovf_head", 32'(rd_byte), 32'h22);
        chk("rxovf_xfer", 32'(xfer), 10);

        // reset in WAIT_RX with bytes queued
        do_reset();
        go = 1'b1;
        wr(8'h31);
        wait_xfers(1);
        go = 1'b0;
        for (int i = 0; i < 9; i++) wr(8'h40 + 8'(i));
        chk("mid_tx_ovf", 32'(tx_ovf), 1);
        go = 1'b1;
        wait_pulses(2);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_tx_dv", 32'(tx_dv), 0);
        chk("mid_tx_level", 32'(tx_level), 0);
        chk("mid_rx_level", 32'(rx_level), 0);
        chk("mid_xfer", 32'(xfer), 0);
        chk("mid_rx_empty", 32'(rx_empty), 1);
        chk("mid_flags", 32'({tx_ovf, rx_ovf}), 0);
        chk("mid_busy0", 32'(busy), 0);
        rst = 1'b0;

        // counter wrap on the CNT_W=4 instance after 17 transfers
        do_reset();
        loopback = 1'b0; echo = 8'h55; go = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'(i));
        wait_xfers(8);
        for (int i = 0; i < 8; i++) wr(8'(i));
        wait_xfers(16);
        chk("wrap_xfer4_at16", 32'(xfer_4), 0);
        wr(8'hEE);
        wait_xfers(17);
        chk("wrap_xfer16", 32'(xfer), 17);
        chk("wrap_xfer4", 32'(xfer_4), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_byte_streamer.md
# spi_byte_streamer

Byte-queueing front end that sits directly upstream of the SPI master (`SPI_Master_AllModes`). It buffers outgoing bytes in a TX FIFO and hands them to the master one at a time over the master's `i_TX_DV`/`o_TX_Ready` handshake. It captures each returned byte (`o_RX_DV`/`o_RX_Byte`) into an RX FIFO, so multi-byte bursts run back-to-back without per-byte intervention from switch/button logic or a host.

## Interface
- `DEPTH`, 8: entries per FIFO (TX and RX); power of two, ≥2.
- `CNT_W`, 16: width of the completed-transfer counter.

Ports:
- `i_Clk`  in  1  system clock; all logic on rising edge.
- `i_Rst`  in  1  synchronous, active-high reset.
- `i_Wr_DV`  in  1  push `i_Wr_Byte` into TX FIFO this cycle.
- `i_Wr_Byte`  in  8  byte to queue.
- `i_Go`  in  1  1 = issue queued bytes to master; 0 = hold (gather mode).
- `i_Rd_En`  in  1  pop head of RX FIFO.
- `o_Rd_Byte`  out  8  RX FIFO head (first-word-fall-through); 0 when empty.
- `o_TX_Full`  out  1  TX FIFO full.
- `o_TX_Level`  out  $clog2(DEPTH)+1  TX FIFO occupancy.
- `o_RX_Empty`  out  1  RX FIFO empty.
- `o_RX_Level`  out  $clog2(DEPTH)+1  RX FIFO occupancy.
- `o_TX_Ovf`  out  1  sticky: write attempted while TX full.
- `o_RX_Ovf`  out  1  sticky: received byte dropped because RX full.
- `o_Busy`  out  1  state ≠ IDLE.
- `o_Xfer_Count`  out  CNT_W  bytes completed since reset.
- `o_TX_DV`  out  1  to master `i_TX_DV`.
- `o_TX_Byte`  out  8  to master `i_TX_Byte`.
- `i_TX_Ready`  in  1  from master `o_TX_Ready`.
- `i_RX_DV`  in  1  from master `o_RX_DV`.
- `i_RX_Byte`  in  8  from master `o_RX_Byte`.

## Operation
- **Reset values:** `i_Rst`=1 clears both FIFOs and returns the FSM to IDLE. All outputs go to 0 except `o_RX_Empty`=1. Sticky flags and the counter clear.
- **TX FIFO write:**
  - `i_Wr_DV` while not full stores the byte.
  - `i_Wr_DV` while full drops the byte and sets `o_TX_Ovf`.
  - A write and an FSM pop in the same cycle are both honoured. Level is unchanged; a write into a full FIFO in a pop cycle is accepted.
- **FSM states:**
  - IDLE: if `i_Go` & TX not empty & `i_TX_Ready`, go to ISSUE.
  - ISSUE (exactly 1 cycle): `o_TX_DV`=1, `o_TX_Byte`=TX head, pop TX FIFO, go to WAIT_RX.
  - WAIT_RX: on `i_RX_DV`, push `i_RX_Byte` into the RX FIFO (or set `o_RX_Ovf` and drop it if full), increment `o_Xfer_Count`, go to WAIT_RDY.
  - WAIT_RDY: stay at least 1 cycle; go to IDLE when `i_TX_Ready`=1.
- **Driven-output defaults:** `o_TX_DV` is 0 in every state other than ISSUE. `o_TX_Byte` holds the last issued byte outside ISSUE.
- **`i_Go` deassertion:** dropping `i_Go` mid-byte does not abort. The current byte completes and the FSM stops in IDLE.
- **Ignored input:** `i_RX_DV` outside WAIT_RX is ignored; nothing is pushed and nothing is counted.
- **RX FIFO read:** `i_Rd_En` when empty is ignored. A read and a push in the same cycle are both honoured, and a push into a full RX FIFO in a pop cycle is accepted.
- **Counter:** `o_Xfer_Count` wraps from 2^CNT_W−1 to 0.
- **Pointers:** FIFO pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from the occupancy counters.
- **Reset mid-transfer:** the FSM returns to IDLE and `o_TX_DV` is 0 from the next cycle. The byte in flight is lost. The SPI master is reset by its own `i_Rst_L`; the top level ties it to the same source.

## Timing
- **Issue latency:** issue conditions true at edge N gives `o_TX_DV`=1 in cycle N+1, for exactly one cycle. The TX FIFO level drops at edge N+1.
- **Write to issue:** a write at edge N into an empty FIFO, with `i_Go`=1 and master ready, gives `o_TX_DV` in cycle N+2.
- **RX capture:** `i_RX_DV` sampled at edge M in WAIT_RX gives the byte visible on `o_Rd_Byte` and the counter incremented after edge M.
- **Minimum gap:** two consecutive `o_TX_DV` pulses are at least 4 cycles apart (ISSUE, WAIT_RX ≥1, WAIT_RDY ≥1, IDLE). In practice the gap is dominated by the master (16·CLKS_PER_HALF_BIT).
- **Combinational path:** `o_Rd_Byte` is combinational from the RX head pointer and memory. All other outputs are registered.

## Test plan
- **Single byte:** reset; write 0xA5; `i_Go`=1; master model echoes 0x3C. Required: exactly one `o_TX_DV` pulse with 0xA5, `o_Rd_Byte`=0x3C, `o_Xfer_Count`=1, `o_Busy` returns to 0.
- **Burst with loopback:** `i_Go`=0; write 0x01..0x08 (DEPTH=8); expect `o_TX_Full`=1 and `o_TX_Level`=8. Write 0x09; expect `o_TX_Ovf`=1. Set `i_Go`=1 with MOSI looped to MISO. Required: RX reads return 0x01..0x08 in order, count=8.
- **Hold via `i_Go`:** drop `i_Go` during the 3rd byte. Required: the 3rd byte completes, no 4th `o_TX_DV`, `o_TX_Level`=DEPTH−3.
- **RX overflow and simultaneous events:** never read; send 9 bytes. Required: `o_RX_Ovf`=1, RX level=8, head=first byte. Then `i_Rd_En` and `i_RX_DV` in the same cycle at full. Required: level stays 8, no new overflow.
- **Reset mid-transfer:** assert `i_Rst` in WAIT_RX with 3 bytes queued. Required: next cycle `o_TX_DV`=0, levels=0, count=0, `o_RX_Empty`=1, flags=0.
- **Counter wrap:** CNT_W=4; run 17 transfers. Required: `o_Xfer_Count`=1.
